// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: req/ack memory responder with read/write wait states and a preload port
module cpu_mem_responder #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4096,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LIM = DEPTH[ADDR_W:0];
    localparam logic [3:0] RD_W = RD_WAIT[3:0];
    localparam logic [3:0] WR_W = WR_WAIT[3:0];

    generate
        if (RD_WAIT < 0 || RD_WAIT > 15 || WR_WAIT < 0 || WR_WAIT > 15) begin : g_bad_wait
            $error("cpu_mem_responder: RD_WAIT and WR_WAIT must be in 0..15");
        end
    endgenerate

    logic [1:0]        state, next_state;
    logic [3:0]        cnt;
    logic              we_l;
    logic [ADDR_W-1:0] addr_l;
    logic [DATA_W-1:0] wdata_l;
    logic              err_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [3:0]        wait_sel;
    logic              do_acc, acc_we, acc_oor, ld_oor;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    // Access operands: live inputs for a zero-wait access in IDLE, latched copies otherwise
    always_comb begin
        wait_sel  = we ? WR_W : RD_W;
        acc_we    = (state == S_IDLE) ? we : we_l;
        acc_addr  = (state == S_IDLE) ? addr : addr_l;
        acc_wdata = (state == S_IDLE) ? wdata : wdata_l;
        acc_oor   = {1'b0, acc_addr} >= LIM;
        ld_oor    = {1'b0, ld_addr} >= LIM;
        do_acc    = !rst && (((state == S_IDLE) && req && (wait_sel == 4'd0)) ||
                             ((state == S_WAIT) && (cnt == 4'd0)));
        next_state = (state == S_IDLE) ? (req ? (do_acc ? S_ACK : S_WAIT) : S_IDLE) :
                     (state == S_WAIT) ? (do_acc ? S_ACK : S_WAIT) : S_IDLE;
    end

    assign ack      = state == S_ACK;
    assign busy     = state != S_IDLE;
    assign err      = err_q;
    assign ld_ready = !rst && (state == S_IDLE) && !req && ld_valid;

    // Array writes: a CPU write at its access edge, else an accepted in-range preload
    always_ff @(posedge clk) begin
        if (do_acc && acc_we && !acc_oor)
            mem[acc_addr[IDX_W-1:0]] <= acc_wdata;
        else if (ld_ready && !ld_oor)
            mem[ld_addr[IDX_W-1:0]] <= ld_data;
    end

    // Control state, request latches, wait counter, read data and error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            we_l    <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
            err_q   <= 1'b0;
            rdata   <= '0;
        end else begin
            if ((state == S_IDLE) && req) begin
                we_l    <= we;
                addr_l  <= addr;
                wdata_l <= wdata;
                cnt     <= (wait_sel == 4'd0) ? 4'd0 : wait_sel - 4'd1;
            end
            if ((state == S_WAIT) && (cnt != 4'd0))
                cnt <= cnt - 4'd1;
            if (do_acc) begin
                err_q <= acc_oor;
                if (!acc_we)
                    rdata <= acc_oor ? '0 : mem[acc_addr[IDX_W-1:0]];
            end
            if (state == S_ACK)
                err_q <= 1'b0;
            state <= next_state;
        end
    end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: table-driven and scoreboard checks on two responder configurations
module tb_cpu_mem_responder;
    typedef struct {
        logic        w;
        logic [11:0] a;
        logic [7:0]  wd;
        logic [7:0]  rd;
        logic        er;
        int          lat;
    } vec_t;

    typedef struct {
        logic [7:0] rd;
        logic       er;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0, we = '0, ack, err, busy, ld_valid = '0, ld_ready;
    logic [11:0] addr [2];
    logic [11:0] ld_addr [2];
    logic [7:0]  wdata [2];
    logic [7:0]  ld_data [2];
    logic [7:0]  rdata [2];
    logic [7:0]  model_rd [2];

    exp_t q0[$];
    exp_t q1[$];
    vec_t tbl[7];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // dut A: slow reads, single-wait writes
    cpu_mem_responder #(.ADDR_W(12), .DATA_W(8), .DEPTH(256), .RD_WAIT(2), .WR_WAIT(1)) u_a (
        .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
        .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0]),
        .ld_valid(ld_valid[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .ld_ready(ld_ready[0])
    );

    // dut B: zero-wait reads, three-wait writes
    cpu_mem_responder #(.ADDR_W(12), .DATA_W(8), .DEPTH(256), .RD_WAIT(0), .WR_WAIT(3)) u_b (
        .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
        .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1]),
        .ld_valid(ld_valid[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .ld_ready(ld_ready[1])
    );

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push_exp(int d, logic [7:0] rd, logic er);
        exp_t e;
        e.rd = rd;
        e.er = er;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    task automatic pop_check(int d);
        exp_t e;
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack dut%0d at %0t", d, $time);
        end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check(d == 0 ? "rdata_a" : "rdata_b", rdata[d], e.rd);
            check(d == 0 ? "err_a" : "err_b", err[d], e.er);
        end
    endtask

    // Scoreboard: every ack pops the oldest expected response for that dut
    always @(negedge clk) begin
        if (ack[0]) pop_check(0);
        if (ack[1]) pop_check(1);
    end

    task automatic wait_ack(int d, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            check("busy", busy[d], 1);
        end while (!ack[d] && n < 20);
        check("ack_seen", ack[d], 1);
    endtask

    task automatic access(int d, logic w, logic [11:0] a, logic [7:0] wd, logic [7:0] rd, logic er, int lat);
        int n;
        if (!w) model_rd[d] = rd;
        push_exp(d, model_rd[d], er);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        @(posedge clk);
        #1 req[d] = 1'b0;
        wait_ack(d, n);
        check("latency", n, lat);
        @(posedge clk);
        #1;
    endtask

    task automatic preload(int d, logic [11:0] a, logic [7:0] v);
        ld_valid[d] = 1'b1; ld_addr[d] = a; ld_data[d] = v;
        @(negedge clk);
        check("ld_ready", ld_ready[d], 1);
        @(posedge clk);
        #1 ld_valid[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0] = '{1'b0, 12'h002, 8'h00, 8'h33, 1'b0, 3};
        tbl[1] = '{1'b1, 12'h010, 8'hA5, 8'h00, 1'b0, 2};
        tbl[2] = '{1'b0, 12'h010, 8'h00, 8'hA5, 1'b0, 3};
        tbl[3] = '{1'b0, 12'h300, 8'h00, 8'h00, 1'b1, 3};
        tbl[4] = '{1'b1, 12'h300, 8'h77, 8'h00, 1'b1, 2};
        tbl[5] = '{1'b0, 12'h000, 8'h00, 8'h11, 1'b0, 3};
        tbl[6] = '{1'b0, 12'h003, 8'h00, 8'h44, 1'b0, 3};
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; wdata[d] = '0; ld_addr[d] = '0; ld_data[d] = '0; model_rd[d] = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ack", ack[d], 0);
            check("rst_err", err[d], 0);
            check("rst_busy", busy[d], 0);
            check("rst_rdata", rdata[d], 0);
            check("rst_ld_ready", ld_ready[d], 0);
        end
        rst = 1'b0;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++)
                preload(d, 12'(i), 8'(8'h11 * (i + 1)));
        preload(1, 12'h005, 8'h44);

        for (int i = 0; i < 7; i++)
            access(0, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].er, tbl[i].lat);

        // latched operands hold while the requester changes lines during WAIT
        model_rd[0] = 8'h22;
        push_exp(0, 8'h22, 1'b0);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 12'h001;
        @(posedge clk);
        #1 req[0] = 1'b0; we[0] = 1'b1; addr[0] = 12'h002; wdata[0] = 8'hEE;
        wait_ack(0, n);
        check("wait_ignore_lat", n, 3);
        @(posedge clk);
        #1;
        access(0, 1'b0, 12'h002, 8'h00, 8'h33, 1'b0, 3);

        // CPU request beats a simultaneous preload; preload lands in the next free IDLE cycle
        model_rd[0] = 8'h11;
        push_exp(0, 8'h11, 1'b0);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 12'h000;
        ld_valid[0] = 1'b1; ld_addr[0] = 12'h008; ld_data[0] = 8'h5A;
        @(negedge clk);
        check("ld_stall_idle", ld_ready[0], 0);
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(negedge clk);
        check("ld_stall_busy", ld_ready[0], 0);
        wait_ack(0, n);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ld_after", ld_ready[0], 1);
        @(posedge clk);
        #1 ld_valid[0] = 1'b0;
        access(0, 1'b0, 12'h008, 8'h00, 8'h5A, 1'b0, 3);

        // zero-wait reads under continuous req: one ack every two cycles
        push_exp(1, 8'h11, 1'b0);
        push_exp(1, 8'h22, 1'b0);
        push_exp(1, 8'h33, 1'b0);
        model_rd[1] = 8'h33;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 12'h000;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 5) req[1] = 1'b0;
            else if (c % 2 == 1) begin we[1] = 1'b1; addr[1] = 12'h003; wdata[1] = 8'hFF; end
            else begin we[1] = 1'b0; addr[1] = 12'(c / 2); end
            @(negedge clk);
            check("b2b_ack", ack[1], c % 2);
        end
        @(posedge clk);
        #1;
        access(1, 1'b0, 12'h003, 8'h00, 8'h44, 1'b0, 1);

        // reset during a write's wait phase abandons it
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 12'h005; wdata[1] = 8'hA0;
        @(posedge clk);
        #1 req[1] = 1'b0;
        @(negedge clk);
        check("rstmid_busy_before", busy[1], 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rstmid_busy", busy[1], 0);
        check("rstmid_ack", ack[1], 0);
        model_rd[0] = 8'h00;
        model_rd[1] = 8'h00;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rstmid_no_ack", ack[1], 0);
        end
        @(posedge clk);
        #1;
        access(1, 1'b0, 12'h005, 8'h00, 8'h44, 1'b0, 1);

        repeat (3) @(posedge clk);
        check("queue_empty", q0.size() + q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
